tx_intf_s_axis_to_pl: RTL and testbench
=======================================

Name: tx_intf_s_axis_to_pl

Overview:
- TX-side counterpart of the rx DMA path: accepts one packet per MM2S transfer from the Xilinx AXI DMA on a 64-bit s_axis.
- Strips a 2-word DMA header (rate/len, target TSF) and publishes it to the tx path.
- Passes payload words to the tx accumulator with flow control and checks that the word count matches pkt_len.
- Recovers from tlast mismatch and DMA stall, and raises a delayed tx_pkt_intr to the PS after each packet completes.

Parameters:
- C_S00_AXIS_TDATA_WIDTH, 64, s_axis and payload word width.
- TSF_TIMER_WIDTH, 64, width of target TSF field.
- MAX_BIT_NUM_DMA_SYMBOL, 14, width of payload word counters.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  synchronous, active-high reset.
- s_axis_tdata  in  64  DMA MM2S data.
- s_axis_tvalid  in  1  DMA data valid.
- s_axis_tlast  in  1  last word of the DMA transfer.
- s_axis_tready  out  1  accept.
- data_to_acc  out  64  payload word.
- data_valid_to_acc  out  1  payload word valid.
- data_ready_from_acc  in  1  accumulator can take a word.
- pkt_rate  out  8  {rate_ht,3'b0,rate[3:0]}.
- pkt_len  out  16  PSDU byte length.
- ht_sgi  out  1  short GI flag.
- tsf_target  out  64  scheduled TX time.
- hdr_valid  out  1  1-cycle pulse; header outputs valid from this cycle on.
- tx_abort  out  1  1-cycle pulse on any error exit.
- monitor_num_dma_symbol  out  14  expected payload words of the current packet.
- timeout_enable  in  1  enable stall recovery.
- timeout_top  in  13  stall limit in 1 µs ticks.
- tsf_pulse_1M  in  1  1 µs tick.
- count_top  in  15  interrupt delay, clk cycles.
- tx_pkt_intr  out  1  1-cycle interrupt pulse.
- err_flags  out  3  sticky {timeout, overrun, underrun}; cleared by rst or by the next hdr_valid.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- Header word0 layout:
  - [63:54] reserved, 0.
  - [53] ht_sgi.
  - [52] rate_ht.
  - [51:48] rate[3:0].
  - [47:32] pkt_len.
  - [31:0] reserved.
- Header word1: tsf_target.
- Expected payload words: N = pkt_len[15:3] + (pkt_len[2:0]!=0), computed at 14 bits.
- IDLE: tready=1; on tvalid, latch word0 fields and N, then go HDR1. A tlast on word0 sets underrun, pulses tx_abort, stays IDLE.
- HDR1: tready=1; on tvalid, latch tsf_target and pulse hdr_valid in the next cycle.
  - With tlast: if N==0, go DONE; else set underrun, pulse tx_abort, go IDLE.
  - Without tlast: if N==0, set overrun and go DRAIN; else go PAYLOAD.
- PAYLOAD, zero-latency pass-through:
  - data_to_acc=tdata.
  - data_valid_to_acc=tvalid.
  - tready=data_ready_from_acc.
  - A word transfers when tvalid&&tready.
  - cnt increments per transfer.
  - Transfer with tlast and cnt==N-1: go DONE.
  - Transfer with tlast and cnt<N-1: underrun, tx_abort, go IDLE.
  - Transfer with cnt==N-1 and no tlast: overrun, go DRAIN.
- DRAIN: tready=1, data_valid_to_acc=0; discard words until tlast, then pulse tx_abort and go IDLE.
- DONE: single cycle; start the interrupt delay counter; go IDLE.
- Stall timer:
  - Cleared on every accepted word and in IDLE.
  - Increments on tsf_pulse_1M in HDR1/PAYLOAD/DRAIN.
  - When timer>timeout_top and timeout_enable: set the timeout flag, pulse tx_abort, go IDLE.
  - Timeout has priority over a same-cycle word transfer; that word is not accepted (tready forced 0 that cycle).
- Interrupt: counter reloads to 0 on DONE and counts up, saturating at count_top+1. tx_pkt_intr=1 for exactly the cycle in which counter==count_top.
  - count_top=0 gives the interrupt 1 cycle after DONE.
  - A DONE arriving while the counter is running restarts it; only one interrupt is issued.
- rst mid-packet: immediate return to IDLE. Any remainder of the DMA transfer is treated as a new header in IDLE; software must reset the DMA alongside.

Optional Feature:
- Macro TX_INTF_ERR_COUNT_EN.
- When defined, adds output err_count[15:0]: increments on each tx_abort pulse, saturates at 16'hFFFF, cleared only by rst.
- When undefined, the port and its logic are absent.

Decomposition:
- Package tx_intf_pkg holds:
  - state encoding (IDLE, HDR1, PAYLOAD, DRAIN, DONE);
  - header bit-position constants;
  - err_flags bit indices.
- One sub-module, tx_intf_intr_delay: the interrupt delay counter (done pulse, count_top → tx_pkt_intr).

Test Plan:
- pkt_len=20, 2 hdr + 3 payload words with tlast on word 3, ready always 1 → hdr_valid after word1; 3 words pass; DONE; count_top=4 gives tx_pkt_intr 5 cycles after DONE; err_flags=0.
- Same packet, data_ready_from_acc toggling 1010… → tready mirrors it; no word lost or duplicated; cnt ends at 3.
- pkt_len=20, tlast on payload word 2 → underrun=1, tx_abort pulse, no tx_pkt_intr.
- pkt_len=8, 3 payload words → overrun=1; word 2 dropped in DRAIN; tx_abort on tlast.
- timeout_top=5, enable=1, tvalid held 0 after word0 → tx_abort after 6th tick; timeout=1.
- pkt_len=0 with tlast on word1 → DONE, interrupt fires, no payload valid.

Source files
------------

// File: rtl/tx_intf_pkg.sv
// Shared definitions for the tx DMA ingress path: FSM states, the header
// word0 field positions, err_flags bit indices and the payload word count.
package tx_intf_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR1    = 3'd1,
    S_PAYLOAD = 3'd2,
    S_DRAIN   = 3'd3,
    S_DONE    = 3'd4
  } tx_state_t;

  // header word0 layout
  localparam int unsigned HDR_SGI_BIT     = 53;
  localparam int unsigned HDR_RATE_HT_BIT = 52;
  localparam int unsigned HDR_RATE_MSB    = 51;
  localparam int unsigned HDR_RATE_LSB    = 48;
  localparam int unsigned HDR_LEN_MSB     = 47;
  localparam int unsigned HDR_LEN_LSB     = 32;

  // err_flags = {timeout, overrun, underrun}
  localparam int unsigned ERR_UNDERRUN = 0;
  localparam int unsigned ERR_OVERRUN  = 1;
  localparam int unsigned ERR_TIMEOUT  = 2;

  localparam int unsigned NUM_SYM_W = 14;

  // payload words of 8 bytes needed to carry len bytes
  function automatic logic [NUM_SYM_W-1:0] num_dma_symbol(input logic [15:0] len);
    return NUM_SYM_W'(len[15:3]) + NUM_SYM_W'(len[2:0] != 3'd0);
  endfunction

endpackage

// File: rtl/tx_intf_intr_delay.sv
// Delays tx_pkt_intr by count_top+1 cycles after a packet completes.
// Ports: clk, rst (sync, active-high), done (1-cycle packet-complete pulse),
//        count_top (delay), tx_pkt_intr (1-cycle interrupt pulse).
module tx_intf_intr_delay (
  input  logic        clk,
  input  logic        rst,
  input  logic        done,
  input  logic [14:0] count_top,
  output logic        tx_pkt_intr
);

  logic [15:0] r_count;
  logic        r_run;
  logic [15:0] w_top;
  logic        w_hit;

  assign w_top = {1'b0, count_top};
  // r_run suppresses the pulse after reset, when the counter also sits at 0
  assign w_hit = r_run && (r_count == w_top);
  assign tx_pkt_intr = w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_run   <= 1'b0;
    end else if (done) begin
      r_count <= '0;
      r_run   <= 1'b1;
    end else begin
      if (r_count < w_top + 16'd1) r_count <= r_count + 16'd1;
      if (w_hit) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/tx_intf_s_axis_to_pl.sv
// Accepts one packet per DMA MM2S transfer: strips the 2-word header
// (rate/len, target TSF), forwards payload to the tx accumulator with flow
// control, checks payload length against pkt_len, recovers from tlast
// mismatch and stalls, and raises a delayed tx_pkt_intr per good packet.
// Ports: s_axis_* (DMA slave), data_*_acc (accumulator handshake),
//        pkt_rate/pkt_len/ht_sgi/tsf_target/hdr_valid (header out),
//        tx_abort, err_flags, monitor_num_dma_symbol (status),
//        timeout_enable/timeout_top/tsf_pulse_1M (stall recovery),
//        count_top/tx_pkt_intr (interrupt).
// Optional: TX_INTF_ERR_COUNT_EN adds err_count (saturating abort count).
module tx_intf_s_axis_to_pl
  import tx_intf_pkg::*;
#(
  parameter int C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int TSF_TIMER_WIDTH        = 64,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                              s_axis_tvalid,
  input  logic                              s_axis_tlast,
  output logic                              s_axis_tready,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0] data_to_acc,
  output logic                              data_valid_to_acc,
  input  logic                              data_ready_from_acc,
  output logic [7:0]                        pkt_rate,
  output logic [15:0]                       pkt_len,
  output logic                              ht_sgi,
  output logic [TSF_TIMER_WIDTH-1:0]        tsf_target,
  output logic                              hdr_valid,
  output logic                              tx_abort,
  output logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] monitor_num_dma_symbol,
  input  logic                              timeout_enable,
  input  logic [12:0]                       timeout_top,
  input  logic                              tsf_pulse_1M,
  input  logic [14:0]                       count_top,
  output logic                              tx_pkt_intr,
  output logic [2:0]                        err_flags
`ifdef TX_INTF_ERR_COUNT_EN
  ,
  output logic [15:0]                       err_count
`endif
);

  localparam int NSW = MAX_BIT_NUM_DMA_SYMBOL;

  tx_state_t r_state, w_next;

  logic                       r_rate_ht;
  logic [3:0]                 r_rate;
  logic                       r_sgi;
  logic [15:0]                r_len;
  logic [NSW-1:0]             r_num_sym;
  logic [TSF_TIMER_WIDTH-1:0] r_tsf;
  logic                       r_hdr_valid;
  logic                       r_tx_abort;
  logic [2:0]                 r_err_flags;
  logic [NSW-1:0]             r_cnt;
  logic [13:0]                r_stall;

  logic           w_tready;
  logic           w_acc_valid;
  logic           w_xfer;
  logic           w_hdr;
  logic           w_abort;
  logic [2:0]     w_err_set;
  logic           w_active;
  logic           w_timeout;
  logic           w_num_zero;
  logic [NSW-1:0] w_last_idx;

  assign w_active   = (r_state == S_HDR1) || (r_state == S_PAYLOAD) || (r_state == S_DRAIN);
  assign w_timeout  = timeout_enable && w_active && (r_stall > {1'b0, timeout_top});
  assign w_num_zero = (r_num_sym == '0);
  assign w_last_idx = r_num_sym - NSW'(1);
  assign w_xfer     = s_axis_tvalid && w_tready;

  always_comb begin
    w_next      = r_state;
    w_tready    = 1'b0;
    w_acc_valid = 1'b0;
    w_hdr       = 1'b0;
    w_abort     = 1'b0;
    w_err_set   = '0;
    // timeout wins over a word offered in the same cycle: tready stays 0
    if (w_timeout) begin
      w_err_set[ERR_TIMEOUT] = 1'b1;
      w_abort                = 1'b1;
      w_next                 = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_tready = 1'b1;
          if (s_axis_tvalid) begin
            if (s_axis_tlast) begin
              w_err_set[ERR_UNDERRUN] = 1'b1;
              w_abort                 = 1'b1;
            end else begin
              w_next = S_HDR1;
            end
          end
        end
        S_HDR1: begin
          w_tready = 1'b1;
          if (s_axis_tvalid) begin
            w_hdr = 1'b1;
            if (s_axis_tlast) begin
              if (w_num_zero) begin
                w_next = S_DONE;
              end else begin
                w_err_set[ERR_UNDERRUN] = 1'b1;
                w_abort                 = 1'b1;
                w_next                  = S_IDLE;
              end
            end else if (w_num_zero) begin
              w_err_set[ERR_OVERRUN] = 1'b1;
              w_next                 = S_DRAIN;
            end else begin
              w_next = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          w_tready    = data_ready_from_acc;
          w_acc_valid = s_axis_tvalid;
          if (w_xfer) begin
            if (s_axis_tlast) begin
              if (r_cnt == w_last_idx) begin
                w_next = S_DONE;
              end else begin
                w_err_set[ERR_UNDERRUN] = 1'b1;
                w_abort                 = 1'b1;
                w_next                  = S_IDLE;
              end
            end else if (r_cnt == w_last_idx) begin
              w_err_set[ERR_OVERRUN] = 1'b1;
              w_next                 = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          w_tready = 1'b1;
          if (s_axis_tvalid && s_axis_tlast) begin
            w_abort = 1'b1;
            w_next  = S_IDLE;
          end
        end
        S_DONE: begin
          w_next = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rate_ht   <= 1'b0;
      r_rate      <= '0;
      r_sgi       <= 1'b0;
      r_len       <= '0;
      r_num_sym   <= '0;
      r_tsf       <= '0;
      r_hdr_valid <= 1'b0;
      r_tx_abort  <= 1'b0;
      r_err_flags <= '0;
      r_cnt       <= '0;
      r_stall     <= '0;
    end else begin
      r_state     <= w_next;
      r_hdr_valid <= w_hdr;
      r_tx_abort  <= w_abort;
      // a new header clears the sticky flags; errors raised in that same cycle still land
      r_err_flags <= (w_hdr ? 3'b000 : r_err_flags) | w_err_set;

      if (r_state == S_IDLE && s_axis_tvalid && !w_timeout) begin
        r_sgi     <= s_axis_tdata[HDR_SGI_BIT];
        r_rate_ht <= s_axis_tdata[HDR_RATE_HT_BIT];
        r_rate    <= s_axis_tdata[HDR_RATE_MSB:HDR_RATE_LSB];
        r_len     <= s_axis_tdata[HDR_LEN_MSB:HDR_LEN_LSB];
        r_num_sym <= NSW'(num_dma_symbol(s_axis_tdata[HDR_LEN_MSB:HDR_LEN_LSB]));
        r_cnt     <= '0;
      end
      if (w_hdr) r_tsf <= s_axis_tdata[TSF_TIMER_WIDTH-1:0];
      if (r_state == S_PAYLOAD && w_xfer) r_cnt <= r_cnt + NSW'(1);

      if (r_state == S_IDLE || w_xfer) begin
        r_stall <= '0;
      end else if (w_active && tsf_pulse_1M && r_stall != '1) begin
        r_stall <= r_stall + 14'd1;
      end
    end
  end

`ifdef TX_INTF_ERR_COUNT_EN
  logic [15:0] r_err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (r_tx_abort && r_err_count != '1) begin
      r_err_count <= r_err_count + 16'd1;
    end
  end

  assign err_count = r_err_count;
`endif

  tx_intf_intr_delay u_intr_delay (
    .clk         (clk),
    .rst         (rst),
    .done        (r_state == S_DONE),
    .count_top   (count_top),
    .tx_pkt_intr (tx_pkt_intr)
  );

  assign s_axis_tready          = w_tready && !rst;
  assign data_valid_to_acc      = w_acc_valid && !rst;
  assign data_to_acc            = (r_state == S_PAYLOAD) ? s_axis_tdata : '0;
  assign pkt_rate               = {r_rate_ht, 3'b000, r_rate};
  assign pkt_len                = r_len;
  assign ht_sgi                 = r_sgi;
  assign tsf_target             = r_tsf;
  assign hdr_valid              = r_hdr_valid;
  assign tx_abort               = r_tx_abort;
  assign err_flags              = r_err_flags;
  assign monitor_num_dma_symbol = r_num_sym;

endmodule

// File: tb/tb_tx_intf_s_axis_to_pl.sv
module tb_tx_intf_s_axis_to_pl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [63:0] data_to_acc;
  logic        data_valid_to_acc;
  logic        data_ready_from_acc = 1'b0;
  logic [7:0]  pkt_rate;
  logic [15:0] pkt_len;
  logic        ht_sgi;
  logic [63:0] tsf_target;
  logic        hdr_valid;
  logic        tx_abort;
  logic [13:0] monitor_num_dma_symbol;
  logic        timeout_enable;
  logic [12:0] timeout_top;
  logic        tsf_pulse_1M;
  logic [14:0] count_top;
  logic        tx_pkt_intr;
  logic [2:0]  err_flags;
`ifdef TX_INTF_ERR_COUNT_EN
  logic [15:0] err_count;
`endif

  always #5 clk = ~clk;

  tx_intf_s_axis_to_pl #(
    .C_S00_AXIS_TDATA_WIDTH (64),
    .TSF_TIMER_WIDTH        (64),
    .MAX_BIT_NUM_DMA_SYMBOL (14)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .s_axis_tdata           (s_axis_tdata),
    .s_axis_tvalid          (s_axis_tvalid),
    .s_axis_tlast           (s_axis_tlast),
    .s_axis_tready          (s_axis_tready),
    .data_to_acc            (data_to_acc),
    .data_valid_to_acc      (data_valid_to_acc),
    .data_ready_from_acc    (data_ready_from_acc),
    .pkt_rate               (pkt_rate),
    .pkt_len                (pkt_len),
    .ht_sgi                 (ht_sgi),
    .tsf_target             (tsf_target),
    .hdr_valid              (hdr_valid),
    .tx_abort               (tx_abort),
    .monitor_num_dma_symbol (monitor_num_dma_symbol),
    .timeout_enable         (timeout_enable),
    .timeout_top            (timeout_top),
    .tsf_pulse_1M           (tsf_pulse_1M),
    .count_top              (count_top),
    .tx_pkt_intr            (tx_pkt_intr),
    .err_flags              (err_flags)
`ifdef TX_INTF_ERR_COUNT_EN
    ,
    .err_count              (err_count)
`endif
  );

  typedef struct {
    logic [7:0]  rate;
    logic [15:0] len;
    logic        sgi;
    logic [63:0] tsf;
    logic [13:0] n;
  } hdr_t;

  logic [63:0] exp_data_q[$];
  hdr_t        exp_hdr_q[$];
  logic [2:0]  exp_abort_q[$];
  int unsigned exp_intr_q[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned n_abort  = 0;
  int unsigned n_intr   = 0;
  int unsigned cyc      = 0;
  int unsigned ready_mode = 0;
  int unsigned gap_pct    = 0;
  logic [2:0]  model_flags = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  // accumulator back-pressure: 0 = always ready, 1 = toggle, 2 = random
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       data_ready_from_acc = 1'b1;
      1:       data_ready_from_acc = ~data_ready_from_acc;
      default: data_ready_from_acc = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents something
  always @(negedge clk) begin
    if (!rst) begin
      if (data_valid_to_acc) begin
        check("tready_mirrors_acc_ready", 64'(s_axis_tready), 64'(data_ready_from_acc));
        if (data_ready_from_acc) begin
          check("payload_expected", 64'(exp_data_q.size() != 0), 64'd1);
          if (exp_data_q.size() != 0) check("payload_word", data_to_acc, exp_data_q.pop_front());
        end
      end
      if (hdr_valid) begin
        check("hdr_expected", 64'(exp_hdr_q.size() != 0), 64'd1);
        if (exp_hdr_q.size() != 0) begin
          hdr_t h;
          h = exp_hdr_q.pop_front();
          check("hdr_pkt_rate", 64'(pkt_rate), 64'(h.rate));
          check("hdr_pkt_len", 64'(pkt_len), 64'(h.len));
          check("hdr_ht_sgi", 64'(ht_sgi), 64'(h.sgi));
          check("hdr_tsf_target", tsf_target, h.tsf);
          check("hdr_num_dma_symbol", 64'(monitor_num_dma_symbol), 64'(h.n));
        end
      end
      if (tx_abort) begin
        n_abort++;
        check("abort_expected", 64'(exp_abort_q.size() != 0), 64'd1);
        if (exp_abort_q.size() != 0) check("abort_err_flags", 64'(err_flags), 64'(exp_abort_q.pop_front()));
      end
      if (tx_pkt_intr) begin
        n_intr++;
        check("intr_expected", 64'(exp_intr_q.size() != 0), 64'd1);
        if (exp_intr_q.size() != 0) check("intr_cycle", 64'(cyc), 64'(exp_intr_q.pop_front()));
      end
    end
  end

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // offer one word; returns the negedge cycle count just before the accepting edge
  task automatic send_word(input logic [63:0] d, input logic last, output int unsigned acc_cyc);
    bit ok;
    ok = 1'b0;
    acc_cyc = 0;
    while ($urandom_range(0, 99) < gap_pct) idle(1);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        acc_cyc = cyc;
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL word_accept_timeout: got no tready within 200 cycles, expected acceptance");
    end else begin
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tdata  = {$urandom(), $urandom()};
  endtask

  // total = number of words in the DMA transfer including the 2 header words
  task automatic send_packet(input int unsigned len, input int unsigned total);
    int unsigned n, p, fwd, ac, e;
    logic [15:0] l16;
    logic [63:0] w0, w1;
    logic [63:0] pay[$];
    logic        sgi, rht, done_exp;
    logic [3:0]  rate;
    hdr_t        h;
    l16  = len[15:0];
    n    = (len + 7) / 8;
    p    = (total >= 2) ? total - 2 : 0;
    sgi  = 1'($urandom_range(0, 1));
    rht  = 1'($urandom_range(0, 1));
    rate = 4'($urandom_range(0, 15));
    w0   = {10'd0, sgi, rht, rate, l16, $urandom()};
    w1   = {$urandom(), $urandom()};
    done_exp = 1'b0;
    fwd  = 0;
    if (total == 1) begin
      model_flags[0] = 1'b1;
      exp_abort_q.push_back(model_flags);
    end else begin
      h.rate = {rht, 3'b000, rate};
      h.len  = l16;
      h.sgi  = sgi;
      h.tsf  = w1;
      h.n    = 14'(n);
      exp_hdr_q.push_back(h);
      model_flags = 3'b000;
      if (p == n) begin
        fwd = n;
        done_exp = 1'b1;
      end else if (p < n) begin
        fwd = p;
        model_flags[0] = 1'b1;
      end else begin
        fwd = n;
        model_flags[1] = 1'b1;
      end
      if (!done_exp) exp_abort_q.push_back(model_flags);
    end
    for (int unsigned i = 0; i < p; i++) begin
      pay.push_back({$urandom(), $urandom()});
      if (i < fwd) exp_data_q.push_back(pay[i]);
    end
    send_word(w0, total == 1, ac);
    if (total >= 2) send_word(w1, total == 2, ac);
    for (int unsigned i = 0; i < p; i++) send_word(pay[i], (i + 1) == p, ac);
    if (done_exp) begin
      e = ac + 2 + 32'(count_top);
      // a completion before the pending interrupt fired restarts the delay
      if (exp_intr_q.size() != 0 && exp_intr_q[exp_intr_q.size() - 1] > ac + 1)
        exp_intr_q[exp_intr_q.size() - 1] = e;
      else
        exp_intr_q.push_back(e);
    end
  endtask

  initial begin
    #500000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: got no end of stimulus, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int unsigned i0, a0, len, n, p, r;
    rst            = 1'b1;
    s_axis_tdata   = '0;
    s_axis_tvalid  = 1'b0;
    s_axis_tlast   = 1'b0;
    timeout_enable = 1'b0;
    timeout_top    = 13'd5;
    tsf_pulse_1M   = 1'b0;
    count_top      = 15'd4;
    idle(3);
    @(negedge clk);
    check("rst_tready", 64'(s_axis_tready), 64'd0);
    check("rst_hdr_valid", 64'(hdr_valid), 64'd0);
    check("rst_tx_abort", 64'(tx_abort), 64'd0);
    check("rst_err_flags", 64'(err_flags), 64'd0);
    check("rst_intr", 64'(tx_pkt_intr), 64'd0);
    check("rst_acc_valid", 64'(data_valid_to_acc), 64'd0);
    check("rst_pkt_len", 64'(pkt_len), 64'd0);
    check("rst_tsf_target", tsf_target, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    @(negedge clk);
    check("idle_tready", 64'(s_axis_tready), 64'd1);
    @(posedge clk);
    #1;

    // good packet, accumulator always ready
    i0 = n_intr;
    send_packet(20, 5);
    idle(12);
    check("t1_intr_count", 64'(n_intr), 64'(i0 + 1));
    check("t1_err_flags", 64'(err_flags), 64'd0);

    // same packet with toggling back-pressure
    ready_mode = 1;
    i0 = n_intr;
    send_packet(20, 5);
    idle(12);
    check("t2_intr_count", 64'(n_intr), 64'(i0 + 1));
    ready_mode = 0;

    // underrun: tlast on payload word 2
    i0 = n_intr;
    send_packet(20, 4);
    idle(12);
    check("t3_no_intr", 64'(n_intr), 64'(i0));
    check("t3_err_flags", 64'(err_flags), 64'(model_flags));

    // overrun: pkt_len=8 with 3 payload words
    i0 = n_intr;
    send_packet(8, 5);
    idle(12);
    check("t4_no_intr", 64'(n_intr), 64'(i0));
    check("t4_err_flags", 64'(err_flags), 64'(model_flags));

    // stall after word0: abort only after the 6th tick
    timeout_enable = 1'b1;
    timeout_top    = 13'd5;
    model_flags[2] = 1'b1;
    exp_abort_q.push_back(model_flags);
    a0 = n_abort;
    send_word({10'd0, 2'b00, 4'd3, 16'd20, 32'd0}, 1'b0, r);
    for (int unsigned t = 1; t <= 6; t++) begin
      tsf_pulse_1M = 1'b1;
      idle(1);
      tsf_pulse_1M = 1'b0;
      if (t < 6) begin
        idle(3);
        check("timeout_not_early", 64'(n_abort), 64'(a0));
      end
    end
    for (int i = 0; i < 6 && n_abort == a0; i++) idle(1);
    check("timeout_abort", 64'(n_abort), 64'(a0 + 1));
    check("timeout_err_flags", 64'(err_flags), 64'(model_flags));
    timeout_enable = 1'b0;
    idle(3);

    // zero-length packet completes from HDR1
    i0 = n_intr;
    send_packet(0, 2);
    idle(12);
    check("t6_intr_count", 64'(n_intr), 64'(i0 + 1));

    // randomized traffic
    for (int unsigned k = 0; k < 40; k++) begin
      if (k % 10 == 0) begin
        idle(40);
        count_top  = 15'($urandom_range(0, 8));
        ready_mode = $urandom_range(0, 2);
        gap_pct    = $urandom_range(0, 30);
      end
      len = $urandom_range(0, 80);
      n   = (len + 7) / 8;
      r   = $urandom_range(0, 9);
      if (r == 0) begin
        send_packet(len, 1);
      end else begin
        if (r == 1) p = n + 1 + $urandom_range(0, 1);
        else if (r <= 3) p = (n > 0) ? $urandom_range(0, n - 1) : 1;
        else p = n;
        send_packet(len, p + 2);
      end
    end

    gap_pct = 0;
    idle(60);
    check("leftover_payload", 64'(exp_data_q.size()), 64'd0);
    check("leftover_hdr", 64'(exp_hdr_q.size()), 64'd0);
    check("leftover_abort", 64'(exp_abort_q.size()), 64'd0);
    check("leftover_intr", 64'(exp_intr_q.size()), 64'd0);
`ifdef TX_INTF_ERR_COUNT_EN
    check("err_count", 64'(err_count), 64'(n_abort));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
